shared_ram_arbiter: RTL and testbench

//  Arbitrates the single-port 8-bit sound/shared BRAM between the M68K (shared_ram_cs window, low byte)
//  and the Z80. Sequences each access, returns read data, and generates M68K DTACK and Z80 WAIT.

---
 rtl/shared_ram_arbiter.sv | 108 ++++++++++
 tb/tb_shared_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter: two-master arbiter for the single-port 8-bit shared BRAM (M68K low byte / Z80).
// Sequences each access IDLE -> ACC -> LATCH, returns read data, generates M68K DTACK and Z80 WAIT.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   m68k_cs/rw/lds_n/addr/din    M68K request (cs held until DTACK seen)
//   m68k_dout, m68k_dtack_n      registered read data and DTACK
//   z80_cs/rd_n/wr_n/addr/din    Z80 request (MREQ-qualified select plus strobes)
//   z80_dout, z80_wait_n         registered read data, combinational WAIT
//   ram_addr/we/din, ram_dout    BRAM port (read data valid one clock after ram_addr)
//   contention_cnt               only when SHARED_RAM_STATS_EN is defined: saturating count of
//                                IDLE cycles with both masters requesting
module shared_ram_arbiter #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          reset_n,
`ifdef SHARED_RAM_STATS_EN
   output logic [15:0]   contention_cnt,
`endif
   input  logic          m68k_cs,
   input  logic          m68k_rw,
   input  logic          m68k_lds_n,
   input  logic [AW-1:0] m68k_addr,
   input  logic [7:0]    m68k_din,
   output logic [7:0]    m68k_dout,
   output logic          m68k_dtack_n,
   input  logic          z80_cs,
   input  logic          z80_rd_n,
   input  logic          z80_wr_n,
   input  logic [AW-1:0] z80_addr,
   input  logic [7:0]    z80_din,
   output logic [7:0]    z80_dout,
   output logic          z80_wait_n,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_din,
   input  logic [7:0]    ram_dout
);
   typedef enum logic [1:0] {IDLE, ACC, LATCH} state_t;
   state_t state;
   logic grant_z, last_z, is_rd, m_served, z_served;
   logic z_act, m_req, z_req, pick_z;
   assign z_act  = z80_cs & (~z80_rd_n | ~z80_wr_n);
   assign m_req  = m68k_cs & ~m_served;
   assign z_req  = z_act & ~z_served;
   // round robin: on contention the master that did not win last time gets the RAM
   assign pick_z = z_req & (~m_req | ~last_z);
   assign z80_wait_n = ~reset_n | ~z_req;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         grant_z      <= 1'b0;
         last_z       <= 1'b1;
         is_rd        <= 1'b0;
         m_served     <= 1'b0;
         z_served     <= 1'b0;
         m68k_dout    <= 8'h00;
         m68k_dtack_n <= 1'b1;
         z80_dout     <= 8'h00;
         ram_addr     <= '0;
         ram_we       <= 1'b0;
         ram_din      <= 8'h00;
`ifdef SHARED_RAM_STATS_EN
         contention_cnt <= 16'h0000;
`endif
      end else begin
         ram_we <= 1'b0;
         // served flags gate re-requests until the master deasserts its select
         if (!m68k_cs) begin
            m_served     <= 1'b0;
            m68k_dtack_n <= 1'b1;
         end
         if (!z_act) z_served <= 1'b0;
`ifdef SHARED_RAM_STATS_EN
         if (state == IDLE && m_req && z_req && contention_cnt != 16'hFFFF)
            contention_cnt <= contention_cnt + 16'd1;
`endif
         case (state)
            IDLE: if (m_req | z_req) begin
               grant_z  <= pick_z;
               last_z   <= pick_z;
               ram_addr <= pick_z ? z80_addr : m68k_addr;
               ram_din  <= pick_z ? z80_din : m68k_din;
               ram_we   <= pick_z ? ~z80_wr_n : (~m68k_rw & ~m68k_lds_n);
               // a byte write with lds_n high is neither a RAM write nor a read
               is_rd    <= pick_z ? z80_wr_n : m68k_rw;
               state    <= ACC;
            end
            ACC: state <= LATCH;
            LATCH: begin
               if (grant_z) begin
                  if (is_rd) z80_dout <= ram_dout;
                  if (z_act) z_served <= 1'b1;
               end else begin
                  if (is_rd) m68k_dout <= ram_dout;
                  // a master that dropped its select mid-access gets no handshake
                  if (m68k_cs) begin
                     m_served     <= 1'b1;
                     m68k_dtack_n <= 1'b0;
                  end
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_shared_ram_arbiter.sv
// tb_shared_ram_arbiter: directed and randomized checks of shared_ram_arbiter against a transaction-level model.
module tb_shared_ram_arbiter;
   localparam int AW = 11;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;
   logic m68k_cs, m68k_rw, m68k_lds_n;
   logic [AW-1:0] m68k_addr;
   logic [7:0] m68k_din, m68k_dout;
   logic m68k_dtack_n;
   logic z80_cs, z80_rd_n, z80_wr_n;
   logic [AW-1:0] z80_addr;
   logic [7:0] z80_din, z80_dout;
   logic z80_wait_n;
   logic [AW-1:0] ram_addr;
   logic ram_we;
   logic [7:0] ram_din, ram_dout;
`ifdef SHARED_RAM_STATS_EN
   logic [15:0] contention_cnt;
`endif

   shared_ram_arbiter #(.AW(AW)) dut (
      .clk(clk), .reset_n(reset_n),
`ifdef SHARED_RAM_STATS_EN
      .contention_cnt(contention_cnt),
`endif
      .m68k_cs(m68k_cs), .m68k_rw(m68k_rw), .m68k_lds_n(m68k_lds_n),
      .m68k_addr(m68k_addr), .m68k_din(m68k_din), .m68k_dout(m68k_dout),
      .m68k_dtack_n(m68k_dtack_n),
      .z80_cs(z80_cs), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
      .z80_addr(z80_addr), .z80_din(z80_din), .z80_dout(z80_dout),
      .z80_wait_n(z80_wait_n),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   logic [7:0] mem [0:(1<<AW)-1] = '{default: 8'h00};
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   int pass_cnt = 0;
   int total = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else pass_cnt++;
   endtask

   // Transaction-level model: an access occupies the RAM for three edges; its data
   // comes from the model's own copy of memory, as it stood when the BRAM read it.
   logic [7:0] ref_mem [0:(1<<AW)-1] = '{default: 8'h00};
   int busy;
   bit own_z, rd, m_srv, z_srv, last_z, e_we, e_dtack_n;
   logic [7:0] rdval, e_mdout, e_zdout, e_din;
   logic [AW-1:0] e_addr;
   int cnt;

   function automatic void mreset();
      busy = 0; own_z = 0; rd = 0; m_srv = 0; z_srv = 0; last_z = 1;
      e_we = 0; e_dtack_n = 1; e_mdout = 0; e_zdout = 0; e_din = 0; e_addr = 0;
      rdval = 0; cnt = 0;
   endfunction

   function automatic bit exp_wait();
      return !reset_n || !(z80_cs && (!z80_rd_n || !z80_wr_n) && !z_srv);
   endfunction

   task automatic model_edge();
      bit mreq, zact, zreq, pz;
      if (!reset_n) begin
         mreset();
         return;
      end
      mreq = m68k_cs && !m_srv;
      zact = z80_cs && (!z80_rd_n || !z80_wr_n);
      zreq = zact && !z_srv;
      if (busy == 2) rdval = ref_mem[e_addr];
      if (e_we) ref_mem[e_addr] = e_din;
      e_we = 0;
      if (!m68k_cs) begin
         m_srv = 0;
         e_dtack_n = 1;
      end
      if (!zact) z_srv = 0;
      if (busy == 1) begin
         if (own_z) begin
            if (rd) e_zdout = rdval;
            if (zact) z_srv = 1;
         end else begin
            if (rd) e_mdout = rdval;
            if (m68k_cs) begin
               m_srv = 1;
               e_dtack_n = 0;
            end
         end
         busy = 0;
      end else if (busy == 2) begin
         busy = 1;
      end else if (mreq || zreq) begin
         if (mreq && zreq && cnt < 65535) cnt++;
         pz = (mreq && zreq) ? !last_z : zreq;
         own_z = pz;
         last_z = pz;
         e_addr = pz ? z80_addr : m68k_addr;
         e_din = pz ? z80_din : m68k_din;
         e_we = pz ? !z80_wr_n : (!m68k_rw && !m68k_lds_n);
         rd = pz ? z80_wr_n : m68k_rw;
         busy = 2;
      end
   endtask

   task automatic step();
      #1;
      chk("wait_n", {31'd0, z80_wait_n}, {31'd0, exp_wait()});
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("dtack_n", {31'd0, m68k_dtack_n}, {31'd0, e_dtack_n});
      chk("m68k_dout", {24'd0, m68k_dout}, {24'd0, e_mdout});
      chk("z80_dout", {24'd0, z80_dout}, {24'd0, e_zdout});
      chk("ram_we", {31'd0, ram_we}, {31'd0, e_we});
      chk("ram_addr", {21'd0, ram_addr}, {21'd0, e_addr});
      chk("ram_din", {24'd0, ram_din}, {24'd0, e_din});
`ifdef SHARED_RAM_STATS_EN
      chk("cnt", {16'd0, contention_cnt}, cnt);
`endif
   endtask

   task automatic m_set(input bit cs, input bit rw, input bit lds, input int a, input int d);
      m68k_cs = cs; m68k_rw = rw; m68k_lds_n = lds;
      m68k_addr = AW'(a); m68k_din = 8'(d);
   endtask

   task automatic z_set(input bit cs, input bit rdn, input bit wrn, input int a, input int d);
      z80_cs = cs; z80_rd_n = rdn; z80_wr_n = wrn;
      z80_addr = AW'(a); z80_din = 8'(d);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      step();
      step();
      reset_n = 1'b1;
   endtask

   int m_ph, m_hold, z_ph;

   initial begin
      mreset();
      m_set(0, 1, 1, 0, 0);
      z_set(0, 1, 1, 0, 0);
      do_reset();
      chk("rst_dtack", {31'd0, m68k_dtack_n}, 32'd1);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_addr", {21'd0, ram_addr}, 32'd0);
      chk("rst_wait", {31'd0, z80_wait_n}, 32'd1);
      step();
      // M68K byte write
      m_set(1, 0, 0, 'h010, 'h5A);
      step();
      chk("t1_we", {31'd0, ram_we}, 32'd1);
      chk("t1_addr", {21'd0, ram_addr}, 32'h010);
      chk("t1_din", {24'd0, ram_din}, 32'h5A);
      step();
      chk("t1_we_off", {31'd0, ram_we}, 32'd0);
      chk("t1_nodtack", {31'd0, m68k_dtack_n}, 32'd1);
      step();
      chk("t1_dtack", {31'd0, m68k_dtack_n}, 32'd0);
      m_set(0, 1, 1, 0, 0);
      step();
      chk("t1_dtack_off", {31'd0, m68k_dtack_n}, 32'd1);
      // Z80 read back
      z_set(1, 0, 1, 'h010, 0);
      step();
      chk("t2_wait1", {31'd0, z80_wait_n}, 32'd0);
      step();
      chk("t2_wait2", {31'd0, z80_wait_n}, 32'd0);
      step();
      chk("t2_wait_done", {31'd0, z80_wait_n}, 32'd1);
      chk("t2_dout", {24'd0, z80_dout}, 32'h5A);
      z_set(0, 1, 1, 0, 0);
      step();
      // contention straight after reset: M68K first
      do_reset();
      m_set(1, 1, 0, 'h010, 0);
      z_set(1, 1, 0, 'h020, 'hC3);
      step();
      chk("t3_addr_m", {21'd0, ram_addr}, 32'h010);
      step();
      step();
      chk("t3_dtack", {31'd0, m68k_dtack_n}, 32'd0);
      chk("t3_mdout", {24'd0, m68k_dout}, 32'h5A);
      chk("t3_wait_held", {31'd0, z80_wait_n}, 32'd0);
      step();
      chk("t3_we_z", {31'd0, ram_we}, 32'd1);
      chk("t3_addr_z", {21'd0, ram_addr}, 32'h020);
      chk("t3_din_z", {24'd0, ram_din}, 32'hC3);
      step();
      chk("t3_wait_e4", {31'd0, z80_wait_n}, 32'd0);
      step();
      chk("t3_wait_e5", {31'd0, z80_wait_n}, 32'd1);
`ifdef SHARED_RAM_STATS_EN
      chk("t3_cnt", {16'd0, contention_cnt}, 32'd1);
`endif
      m_set(0, 1, 1, 0, 0);
      z_set(0, 1, 1, 0, 0);
      step();
      // write with lds_n high: handshake but no RAM write
      m_set(1, 0, 1, 'h010, 'hFF);
      step();
      chk("t4_no_we", {31'd0, ram_we}, 32'd0);
      step();
      step();
      chk("t4_dtack", {31'd0, m68k_dtack_n}, 32'd0);
      m_set(0, 1, 1, 0, 0);
      z_set(1, 0, 1, 'h010, 0);
      step();
      step();
      step();
      chk("t4_unchanged", {24'd0, z80_dout}, 32'h5A);
      z_set(0, 1, 1, 0, 0);
      step();
      // M68K holds select after DTACK: exactly one access
      m_set(1, 1, 0, 'h010, 0);
      for (int i = 0; i < 13; i++) step();
      chk("t6_hold_dtack", {31'd0, m68k_dtack_n}, 32'd0);
      m_set(0, 1, 1, 0, 0);
      step();
      chk("t6_release", {31'd0, m68k_dtack_n}, 32'd1);
      m_set(1, 1, 0, 'h020, 0);
      step();
      chk("t6_new_addr", {21'd0, ram_addr}, 32'h020);
      step();
      step();
      chk("t6_dtack", {31'd0, m68k_dtack_n}, 32'd0);
      chk("t6_mdout", {24'd0, m68k_dout}, 32'hC3);
      m_set(0, 1, 1, 0, 0);
      step();
      // reset during ACC of a Z80 write
      z_set(1, 1, 0, 'h030, 'h11);
      step();
      chk("t5_we", {31'd0, ram_we}, 32'd1);
      reset_n = 1'b0;
      z_set(0, 1, 1, 0, 0);
      #1;
      chk("t5_we_clr", {31'd0, ram_we}, 32'd0);
      chk("t5_dtack", {31'd0, m68k_dtack_n}, 32'd1);
      chk("t5_wait", {31'd0, z80_wait_n}, 32'd1);
      step();
      step();
      reset_n = 1'b1;
      step();
      // randomized traffic from both masters, including aborts
      m_ph = 0; m_hold = 0; z_ph = 0;
      for (int n = 0; n < 3000; n++) begin
         if (m_ph == 0) begin
            if ($urandom_range(3) == 0) begin
               m_set(1, 1'($urandom_range(1)), 1'($urandom_range(3) == 0),
                     int'($urandom_range(15)), int'($urandom_range(255)));
               m_ph = 1;
            end
         end else if (m_ph == 1) begin
            if (!m68k_dtack_n) begin
               m_ph = 2;
               m_hold = int'($urandom_range(2));
            end else if ($urandom_range(39) == 0) begin
               m_set(0, 1, 1, 0, 0);
               m_ph = 0;
            end else begin
               m68k_din = 8'($urandom_range(255));
            end
         end
         if (m_ph == 2) begin
            if (m_hold == 0) begin
               m_set(0, 1, 1, 0, 0);
               m_ph = 0;
            end else m_hold--;
         end
         if (z_ph == 0) begin
            if ($urandom_range(3) == 0) begin
               if ($urandom_range(1) == 0) z_set(1, 0, 1, int'($urandom_range(15)), 0);
               else z_set(1, 1, 0, int'($urandom_range(15)), int'($urandom_range(255)));
               z_ph = 1;
            end
         end else if (z80_wait_n || $urandom_range(39) == 0) begin
            z_set(0, 1, 1, 0, 0);
            z_ph = 0;
         end
         step();
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
